// File: rtl/window_counter_control.sv
// rtl/window_counter_control.sv - stall-aware KxK sliding-window control sequencer
// Counts accepted pixels across a multi-frame run and drives line selects, output strobe and coordinates.
module window_counter_control #(
  parameter int DIM_W    = 16,
  parameter int FRAME_W  = 32,
  parameter int KERNEL   = 3,
  parameter int PIPE_LAT = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [DIM_W-1:0]   width,
  input  logic [DIM_W-1:0]   high,
  input  logic [FRAME_W-1:0] frames,
  output logic               in_ready,
  output logic               busy,
  output logic               stop,
  output logic               data_valid_out,
  output logic [KERNEL-2:0]  line_sel,
  output logic [DIM_W-1:0]   out_col,
  output logic [DIM_W-1:0]   out_row,
  output logic [FRAME_W-1:0] out_frame,
  output logic               border,
  output logic               frame_done,
  output logic               cfg_err
);

  localparam int HALO  = (KERNEL - 1) / 2;
  localparam int CNT_W = 2 * DIM_W + FRAME_W;
  localparam int NSEL  = KERNEL - 1;

  localparam logic [DIM_W-1:0]   ONE_D  = DIM_W'(1);
  localparam logic [DIM_W-1:0]   HALO_D = DIM_W'(HALO);
  localparam logic [DIM_W-1:0]   K_D    = DIM_W'(KERNEL);
  localparam logic [FRAME_W-1:0] ONE_F  = FRAME_W'(1);
  localparam logic [CNT_W-1:0]   ONE_C  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   w_q, w_d, h_q, h_d;
  logic [FRAME_W-1:0] f_q, f_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               stop_q, stop_d;
  logic               data_valid_out_q, data_valid_out_d;
  logic [NSEL-1:0]    line_sel_q, line_sel_d;
  logic [DIM_W-1:0]   out_col_q, out_col_d;
  logic [DIM_W-1:0]   out_row_q, out_row_d;
  logic [FRAME_W-1:0] out_frame_q, out_frame_d;
  logic               border_q, border_d;
  logic               frame_done_q, frame_done_d;
  logic               cfg_err_q, cfg_err_d;

  logic [CNT_W-1:0]   n_total, t_lat, end_cnt, cnt_inc;
  logic               idle_like, cfg_bad, start_ok, advance;
  logic [DIM_W-1:0]   cur_col, cur_row;
  logic [FRAME_W-1:0] cur_frame;

  always_comb begin
    n_total = CNT_W'(w_q) * CNT_W'(h_q) * CNT_W'(f_q);
    t_lat   = CNT_W'(HALO) * CNT_W'(w_q) + CNT_W'(PIPE_LAT - 1);
    end_cnt = n_total + t_lat;
    cnt_inc = cnt_q + ONE_C;

    idle_like = (state_q == IDLE) || (state_q == DONE);
    cfg_bad   = (width < K_D) || (high < K_D) || (frames == '0);
    start_ok  = start && idle_like && !cfg_bad;
    advance   = ((state_q == RUN) && in_valid) || (state_q == FLUSH);
  end

  // Coordinate registers hold the strobed pixel and step one cycle after each strobe,
  // so cur_* is the pixel the next strobe (if any) will label.
  always_comb begin
    cur_col   = out_col_q;
    cur_row   = out_row_q;
    cur_frame = out_frame_q;
    if (data_valid_out_q) begin
      if (out_col_q == w_q - ONE_D) begin
        cur_col = '0;
        if (out_row_q == h_q - ONE_D) begin
          cur_row   = '0;
          cur_frame = out_frame_q + ONE_F;
        end else begin
          cur_row = out_row_q + ONE_D;
        end
      end else begin
        cur_col = out_col_q + ONE_D;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    w_d              = w_q;
    h_d              = h_q;
    f_d              = f_q;
    cnt_d            = cnt_q;
    stop_d           = stop_q;
    line_sel_d       = line_sel_q;
    out_col_d        = cur_col;
    out_row_d        = cur_row;
    out_frame_d      = cur_frame;
    data_valid_out_d = 1'b0;
    border_d         = 1'b0;
    frame_done_d     = 1'b0;
    cfg_err_d        = 1'b0;

    if (start_ok) begin
      state_d     = RUN;
      w_d         = width;
      h_d         = high;
      f_d         = frames;
      cnt_d       = '0;
      stop_d      = 1'b0;
      line_sel_d  = '0;
      out_col_d   = '0;
      out_row_d   = '0;
      out_frame_d = '0;
    end else begin
      cfg_err_d = start && idle_like && cfg_bad;
      if (advance) begin
        cnt_d = cnt_inc;
        if (cnt_inc > t_lat) begin
          data_valid_out_d = 1'b1;
          border_d = (cur_col < HALO_D) || (cur_col > w_q - ONE_D - HALO_D) ||
                     (cur_row < HALO_D) || (cur_row > h_q - ONE_D - HALO_D);
          frame_done_d = (cur_col == w_q - ONE_D) && (cur_row == h_q - ONE_D);
        end
        for (int i = 0; i < NSEL; i++) begin
          if (cnt_inc >= CNT_W'(i + 1) * CNT_W'(w_q) + CNT_W'(2)) begin
            line_sel_d[i] = 1'b1;
          end
        end
        if ((state_q == RUN) && (cnt_inc == n_total)) begin
          state_d = FLUSH;
        end else if ((state_q == FLUSH) && (cnt_inc == end_cnt)) begin
          state_d = DONE;
          stop_d  = 1'b1;
        end
      end
    end

    in_ready_d = (state_d == RUN);
    busy_d     = (state_d == RUN) || (state_d == FLUSH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      w_q              <= '0;
      h_q              <= '0;
      f_q              <= '0;
      cnt_q            <= '0;
      in_ready_q       <= 1'b0;
      busy_q           <= 1'b0;
      stop_q           <= 1'b0;
      data_valid_out_q <= 1'b0;
      line_sel_q       <= '0;
      out_col_q        <= '0;
      out_row_q        <= '0;
      out_frame_q      <= '0;
      border_q         <= 1'b0;
      frame_done_q     <= 1'b0;
      cfg_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      w_q              <= w_d;
      h_q              <= h_d;
      f_q              <= f_d;
      cnt_q            <= cnt_d;
      in_ready_q       <= in_ready_d;
      busy_q           <= busy_d;
      stop_q           <= stop_d;
      data_valid_out_q <= data_valid_out_d;
      line_sel_q       <= line_sel_d;
      out_col_q        <= out_col_d;
      out_row_q        <= out_row_d;
      out_frame_q      <= out_frame_d;
      border_q         <= border_d;
      frame_done_q     <= frame_done_d;
      cfg_err_q        <= cfg_err_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign busy           = busy_q;
  assign stop           = stop_q;
  assign data_valid_out = data_valid_out_q;
  assign line_sel       = line_sel_q;
  assign out_col        = out_col_q;
  assign out_row        = out_row_q;
  assign out_frame      = out_frame_q;
  assign border         = border_q;
  assign frame_done     = frame_done_q;
  assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_window_counter_control.sv
// tb/tb_window_counter_control.sv - self-checking bench for window_counter_control
// Drives a K=3 and a K=5 instance with identical stimulus and checks both against a reference model.
module tb_window_counter_control;

  localparam int DW = 16;
  localparam int FW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] width = '0;
  logic [DW-1:0] high = '0;
  logic [FW-1:0] frames = '0;

  always #5 clk = ~clk;

  logic [1:0] ir, bs, sp, dv, bd, fdn, ce;
  logic [1:0][DW-1:0] oc, orw;
  logic [1:0][FW-1:0] ofr;
  logic [1:0] ls3;
  logic [3:0] ls5;

  window_counter_control #(.DIM_W(DW), .FRAME_W(FW), .KERNEL(3), .PIPE_LAT(9)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .width(width), .high(high), .frames(frames),
    .in_ready(ir[0]), .busy(bs[0]), .stop(sp[0]), .data_valid_out(dv[0]),
    .line_sel(ls3), .out_col(oc[0]), .out_row(orw[0]), .out_frame(ofr[0]),
    .border(bd[0]), .frame_done(fdn[0]), .cfg_err(ce[0])
  );

  window_counter_control #(.DIM_W(DW), .FRAME_W(FW), .KERNEL(5), .PIPE_LAT(9)) dut5 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .width(width), .high(high), .frames(frames),
    .in_ready(ir[1]), .busy(bs[1]), .stop(sp[1]), .data_valid_out(dv[1]),
    .line_sel(ls5), .out_col(oc[1]), .out_row(orw[1]), .out_frame(ofr[1]),
    .border(bd[1]), .frame_done(fdn[1]), .cfg_err(ce[1])
  );

  int checks = 0;
  int failures = 0;

  // Reference model: spec-level state per instance (0: K=3, 1: K=5).
  bit       m_run[2], m_fl[2], m_stop[2], m_dv[2], m_cfg[2], m_bd[2], m_fd[2];
  longint   m_w[2], m_h[2], m_f[2], m_adv[2], m_col[2], m_row[2], m_fr[2];
  logic [3:0] m_ls[2];

  int r_strobe[2], r_fd, r_busy, r_flush, r_center5;
  longint fd_col, fd_row, fd_fr;

  typedef struct {
    int w; int h; int f;
    bit err3; bit err5;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(string nm, int u, longint got, longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0d expected=%0d", nm, u, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_run[u] = 0; m_fl[u] = 0; m_stop[u] = 0; m_dv[u] = 0; m_cfg[u] = 0;
      m_bd[u] = 0; m_fd[u] = 0; m_adv[u] = 0; m_ls[u] = '0;
      m_w[u] = 0; m_h[u] = 0; m_f[u] = 0; m_col[u] = 0; m_row[u] = 0; m_fr[u] = 0;
    end
  endtask

  task automatic model_step(int u);
    int k, halo;
    longint n, t, idx;
    k = (u == 0) ? 3 : 5;
    halo = (k - 1) / 2;
    m_dv[u] = 0; m_cfg[u] = 0; m_bd[u] = 0; m_fd[u] = 0;
    if (start && !m_run[u] && !m_fl[u]) begin
      if (int'(width) >= k && int'(high) >= k && frames != 0) begin
        m_w[u] = longint'(width); m_h[u] = longint'(high); m_f[u] = longint'(frames);
        m_run[u] = 1; m_adv[u] = 0; m_stop[u] = 0; m_ls[u] = '0;
        m_col[u] = 0; m_row[u] = 0; m_fr[u] = 0;
      end else begin
        m_cfg[u] = 1;
      end
    end else if ((m_run[u] && in_valid) || m_fl[u]) begin
      n = m_w[u] * m_h[u] * m_f[u];
      t = halo * m_w[u] + 8;
      m_adv[u]++;
      if (m_adv[u] > t) begin
        idx = m_adv[u] - t - 1;
        m_dv[u]  = 1;
        m_col[u] = idx % m_w[u];
        m_row[u] = (idx / m_w[u]) % m_h[u];
        m_fr[u]  = idx / (m_w[u] * m_h[u]);
        m_bd[u]  = (m_col[u] < halo) || (m_col[u] >= m_w[u] - halo) ||
                   (m_row[u] < halo) || (m_row[u] >= m_h[u] - halo);
        m_fd[u]  = (m_col[u] == m_w[u] - 1) && (m_row[u] == m_h[u] - 1);
      end
      for (int i = 0; i < k - 1; i++)
        if (m_adv[u] >= (i + 1) * m_w[u] + 2) m_ls[u][i] = 1'b1;
      if (m_run[u] && m_adv[u] == n) begin
        m_run[u] = 0; m_fl[u] = 1;
      end else if (m_fl[u] && m_adv[u] == n + t) begin
        m_fl[u] = 0; m_stop[u] = 1;
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] ls;
    for (int u = 0; u < 2; u++) begin
      ls = (u == 0) ? {2'b00, ls3} : ls5;
      chk("in_ready", u, ir[u], m_run[u]);
      chk("busy", u, bs[u], m_run[u] | m_fl[u]);
      chk("stop", u, sp[u], m_stop[u]);
      chk("data_valid_out", u, dv[u], m_dv[u]);
      chk("cfg_err", u, ce[u], m_cfg[u]);
      chk("frame_done", u, fdn[u], m_fd[u]);
      chk("line_sel", u, ls, m_ls[u]);
      if (m_dv[u]) begin
        chk("out_col", u, oc[u], m_col[u]);
        chk("out_row", u, orw[u], m_row[u]);
        chk("out_frame", u, ofr[u], m_fr[u]);
        chk("border", u, bd[u], m_bd[u]);
      end
    end
  endtask

  task automatic cycle(bit st, bit iv);
    start = st;
    in_valid = iv;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("reset_out_col", 0, oc[0], 0);
    chk("reset_out_frame", 1, ofr[1], 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic tally();
    for (int u = 0; u < 2; u++) if (dv[u]) r_strobe[u]++;
    if (fdn[0]) begin
      r_fd++; fd_col = oc[0]; fd_row = orw[0]; fd_fr = ofr[0];
    end
    if (bs[0]) r_busy++;
    if (bs[0] && !ir[0]) r_flush++;
    if (dv[1] && !bd[1]) r_center5++;
  endtask

  // mode 0: in_valid held high; 1: toggling 1,0; 2: random with ignored mid-run starts;
  // 3: held high plus a start on the FLUSH->DONE edge of the K=3 instance
  task automatic run(int w, int h, int f, int mode);
    bit st, iv;
    int c;
    width = DW'(w); high = DW'(h); frames = FW'(f);
    r_strobe[0] = 0; r_strobe[1] = 0; r_fd = 0; r_busy = 0; r_flush = 0; r_center5 = 0;
    cycle(1'b1, 1'b0);
    tally();
    c = 0;
    while (c < 4000 && (m_run[0] || m_fl[0] || m_run[1] || m_fl[1])) begin
      case (mode)
        0, 3:    iv = 1'b1;
        1:       iv = (c % 2 == 0);
        default: iv = ($urandom % 3 != 0);
      endcase
      st = 1'b0;
      if (mode == 2 && (m_run[0] || m_fl[0]) && (m_run[1] || m_fl[1]))
        st = ($urandom % 40 == 0);
      if (mode == 3 && m_fl[0] && m_adv[0] == m_w[0] * m_h[0] * m_f[0] + m_w[0] + 7)
        st = 1'b1;
      cycle(st, iv);
      tally();
      c++;
    end
    if (c >= 4000) chk("run_timeout", 0, 1, 0);
  endtask

  initial begin
    tbl[0] = '{w: 2, h: 4, f: 1, err3: 1, err5: 1};
    tbl[1] = '{w: 4, h: 4, f: 0, err3: 1, err5: 1};
    tbl[2] = '{w: 4, h: 4, f: 1, err3: 0, err5: 1};
    tbl[3] = '{w: 5, h: 5, f: 1, err3: 0, err5: 0};
    tbl[4] = '{w: 3, h: 3, f: 2, err3: 0, err5: 1};
    tbl[5] = '{w: 7, h: 2, f: 1, err3: 1, err5: 1};

    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b1;
    @(negedge clk);
    check_all();

    foreach (tbl[i]) begin
      width = DW'(tbl[i].w); high = DW'(tbl[i].h); frames = FW'(tbl[i].f);
      cycle(1'b1, 1'b0);
      chk("tbl_cfg_err", 0, ce[0], tbl[i].err3);
      chk("tbl_cfg_err", 1, ce[1], tbl[i].err5);
      chk("tbl_in_ready", 0, ir[0], !tbl[i].err3);
      chk("tbl_in_ready", 1, ir[1], !tbl[i].err5);
      cycle(1'b0, 1'b0);
      chk("tbl_cfg_err_pulse", 0, ce[0], 0);
      do_reset();
    end

    run(4, 4, 1, 3);
    chk("strobes_4x4", 0, r_strobe[0], 16);
    chk("frame_done_4x4", 0, r_fd, 1);
    chk("fd_col", 0, fd_col, 3);
    chk("fd_row", 0, fd_row, 3);
    chk("fd_frame", 0, fd_fr, 0);
    chk("busy_cycles_4x4", 0, r_busy, 28);

    run(4, 4, 1, 0);
    chk("strobes_from_done", 0, r_strobe[0], 16);

    run(4, 4, 1, 1);
    chk("strobes_toggle", 0, r_strobe[0], 16);
    chk("flush_cycles", 0, r_flush, 12);

    run(5, 4, 3, 0);
    chk("strobes_5x4x3", 0, r_strobe[0], 60);
    chk("frame_done_5x4x3", 0, r_fd, 3);

    width = DW'(4); high = DW'(4); frames = FW'(1);
    cycle(1'b1, 1'b0);
    repeat (7) cycle(1'b0, 1'b1);
    do_reset();
    run(4, 4, 1, 0);
    chk("busy_after_reset", 0, r_busy, 28);
    chk("strobes_after_reset", 0, r_strobe[0], 16);

    run(6, 6, 1, 0);
    chk("strobes_k5", 1, r_strobe[1], 36);
    chk("center_k5", 1, r_center5, 4);
    chk("line_sel_k5", 1, ls5, 4'hf);

    for (int r = 0; r < 12; r++)
      run(int'($urandom_range(3, 9)), int'($urandom_range(3, 9)), int'($urandom_range(1, 2)), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_counter_control.md
# window_counter_control

Parametrised control sequencer for the K×K sliding-window filter datapath. It counts accepted input pixels over a multi-frame stream and drives the line-buffer selects, a per-pixel output-valid strobe, and the end-of-stream stop. It also tracks output coordinates, flags border pixels, and pulses at every frame end. It sits between the pixel source handshake and the line-buffer and filter pipeline, and replaces the fixed 3×3 controller with kernel-size-generic, stall-aware, start-triggered operation.

## Interface
- `DIM_W`, 16, width of the `width` and `high` inputs and of the output column/row counters
- `FRAME_W`, 32, width of `frames` and `out_frame`
- `KERNEL`, 3, window size K; odd, 3..7; HALO = (K-1)/2
- `PIPE_LAT`, 9, filter pipeline latency in pixel advances
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; latches the config and begins a run
- `in_valid`  in  1  source pixel available; accepted when `in_ready` is 1
- `width`  in  DIM_W  frame width W in pixels
- `high`  in  DIM_W  frame height H in lines
- `frames`  in  FRAME_W  frame count F
- `in_ready`  out  1  controller accepts input
- `busy`  out  1  run in progress
- `stop`  out  1  end of stream; sticky until the next accepted start
- `data_valid_out`  out  1  one-cycle strobe per output pixel
- `line_sel`  out  K-1  bit i set once line buffer i is primed
- `out_col`  out  DIM_W  column of the current output pixel
- `out_row`  out  DIM_W  row of the current output pixel
- `out_frame`  out  FRAME_W  frame index of the current output pixel
- `border`  out  1  current output pixel lies within HALO of any frame edge
- `frame_done`  out  1  one-cycle pulse with the last output pixel of each frame
- `cfg_err`  out  1  one-cycle pulse when a start is rejected

## Operation
- State machine with states IDLE, RUN, FLUSH, DONE. Reset enters IDLE.
- All outputs are registered and reset to 0; internal counters also reset to 0.
- Config is latched on an accepted start. Inputs `width`, `high` and `frames` are ignored at all other times.
- Accepted start:
  - Conditions: state is IDLE or DONE, W ≥ K, H ≥ K, F ≥ 1.
  - Action: go to RUN; clear the pixel count, `stop`, `line_sel`, `out_col`, `out_row`, `out_frame`.
- Rejected start:
  - A start with a bad config in IDLE or DONE pulses `cfg_err`; state is unchanged.
  - A start in RUN or FLUSH is ignored silently.
- Pixel count `cnt` is CNT_W = 2·DIM_W+FRAME_W bits wide. All products are computed at CNT_W width, so there is no overflow.
- Derived constants:
  - N = W·H·F
  - T = HALO·W + PIPE_LAT − 1
  - END = N + T
- Advance rules:
  - RUN: advance when `in_valid`.
  - FLUSH: advance every cycle with no input accepted; `in_ready` = 0.
  - IDLE, DONE: no advance; `in_valid` is ignored.
- Transitions:
  - RUN → FLUSH when an advance makes `cnt` == N.
  - FLUSH → DONE when an advance makes `cnt` == END; `stop` asserts on that same edge.
- `in_ready` = 1 exactly while in RUN. `busy` = 1 in RUN or FLUSH.
- `data_valid_out` is set on the edge of any advance whose new `cnt` > T, and is 0 otherwise. Exactly N strobes are produced per run.
- Output coordinates:
  - `out_col`, `out_row`, `out_frame` label the pixel whose strobe is high. The first strobe carries (0,0,0).
  - After each strobe `out_col` increments, wrapping at W-1 to 0 and incrementing `out_row`.
  - `out_row` wraps at H-1 to 0 and increments `out_frame`.
- `border` = col < HALO, or col > W-1-HALO, or row < HALO, or row > H-1-HALO. It is valid only with the strobe.
- `frame_done` = strobe AND col == W-1 AND row == H-1.
- `line_sel[i]` is set on the edge where `cnt` first reaches ≥ (i+1)·W + 2. It stays set until the next accepted start or reset.

## Timing
- Start accepted at edge e: `busy` and `in_ready` are high after e. The first input can be accepted at edge e+1.
- Strobe latency: `data_valid_out` rises on the same edge as the advance that crosses T, i.e. after T+1 accepted pixels.
- Stall (`in_valid`=0 in RUN) produces no advance, so no strobe, and `cnt` holds. Strobes are never generated from stall cycles.
- The last input advance and the FLUSH entry occur on the same edge. FLUSH lasts exactly T cycles.
- A start arriving on the same edge as the FLUSH → DONE transition is ignored; a start is accepted from DONE one cycle later.
- Asynchronous reset mid-run clears everything immediately to IDLE. A fresh start is required afterwards.

## Test plan
- K=3, PIPE_LAT=9, W=4, H=4, F=1, `in_valid` held high → T=12; first strobe on the 13th advance; 16 strobes; `frame_done` once with (3,3,0); `stop` after 28 advances; `line_sel[0]` at `cnt`=6, `line_sel[1]` at `cnt`=10.
- Same config, `in_valid` toggling 1,0 → strobes appear only on accept edges; the strobe count is still 16; FLUSH runs 12 back-to-back cycles.
- W=5, H=4, F=3 → 60 strobes; `frame_done` pulses 3 times; `out_frame` steps 0→1→2; `border`=0 only at rows 1..2, columns 1..3.
- start with W=2, and separately start with F=0 → `cfg_err` single pulse; state stays IDLE; `in_ready`=0.
- `rst` low after 7 advances → all outputs 0 immediately; a subsequent start re-runs the full 28-advance sequence.
- KERNEL=5, W=H=6, F=1 → T=20; `line_sel` has 4 bits set at `cnt` 8, 14, 20, 26; `border`=1 for all but the 2×2 center pixels.
